mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between an instruction fetch requester and a
//   data load/store requester. Data normally wins a conflict. Once the
//   instruction side has lost STARVE_MAX conflicts in a row, it is granted
//   instead. Read data is captured one cycle after the grant.
//
// Ports
//   clk, rst_n        : clock and asynchronous active-low reset
//   i_req/i_addr      : instruction fetch request and word address
//   i_gnt             : fetch granted this cycle (combinational)
//   i_rvalid/i_rdata  : fetched word, valid one cycle after i_gnt
//   d_req/d_we/d_addr/d_wdata/d_type : data access request (d_we=1 store)
//   d_gnt             : data access granted this cycle (combinational)
//   d_rvalid/d_rdata  : load result or store acknowledge (d_rdata=0)
//   m_*               : shared memory port (combinational read, negedge write)
//   conflict_cnt      : saturating count of cycles with both requests high

module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [13:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [13:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_type,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_is_store,
    output logic [13:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_type,
    input  logic [31:0] m_loaddata,
    output logic [15:0] conflict_cnt
);

    // Type code used for every instruction fetch and for the idle port
    localparam logic [2:0] LOAD_LW    = 3'b010;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       force_i;

    assign force_i = (starve_cnt == STARVE_LIM);

    // Grant decision: data wins a conflict unless the fetch side is starved.
    // Both grants are held low during reset so nothing is started then.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            i_gnt = i_req && (!d_req || force_i);
            d_gnt = d_req && !i_gnt;
        end
    end

    // Memory port steering; the port idles as a harmless word load of 0
    always_comb begin
        m_is_store = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_type     = LOAD_LW;
        if (i_gnt) begin
            m_addr = i_addr;
        end else if (d_gnt) begin
            m_is_store = d_we;
            m_addr     = d_addr;
            m_wdata    = d_wdata;
            m_type     = d_type;
        end
    end

    // Starvation counter: counts consecutive lost fetch cycles, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (i_req && !i_gnt) begin
            if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Conflict statistics, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (i_req && d_req && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    // Response capture at the edge closing the grant cycle. Read data holds
    // its last value between responses; a store returns zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= i_gnt;
            d_rvalid <= d_gnt;
            if (i_gnt)
                i_rdata <= m_loaddata;
            if (d_gnt)
                d_rdata <= d_we ? 32'd0 : m_loaddata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A small typed memory model sits on the
//   shared port. The bench applies a vector table of single-cycle accesses,
//   then runs hand-written sequences for starvation and reset mid-grant.

module tb_mem_arbiter;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [13:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [13:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_type;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_is_store;
    logic [13:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_type;
    logic [31:0] m_loaddata;
    logic [15:0] conflict_cnt;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_type(d_type), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_is_store(m_is_store), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_type(m_type), .m_loaddata(m_loaddata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: typed combinational read, negedge write
    logic [31:0] mem [0:16383];
    logic [31:0] raw_word;

    always_comb begin
        raw_word = mem[m_addr];
        case (m_type)
            LB:      m_loaddata = {{24{raw_word[7]}}, raw_word[7:0]};
            LH:      m_loaddata = {{16{raw_word[15]}}, raw_word[15:0]};
            LBU:     m_loaddata = {24'd0, raw_word[7:0]};
            LHU:     m_loaddata = {16'd0, raw_word[15:0]};
            default: m_loaddata = raw_word;
        endcase
    end

    always @(negedge clk) begin
        if (m_is_store) begin
            case (m_type)
                SB:      mem[m_addr][7:0]  <= m_wdata[7:0];
                SH:      mem[m_addr][15:0] <= m_wdata[15:0];
                default: mem[m_addr]       <= m_wdata;
            endcase
        end
    end

    typedef struct {
        logic        i_req;
        logic [13:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [13:0] d_addr;
        logic [31:0] d_wdata;
        logic [2:0]  d_type;
        logic        exp_i_gnt;
        logic        exp_d_gnt;
        logic        exp_is_store;
        logic [13:0] exp_m_addr;
        logic        exp_i_rvalid;
        logic [31:0] exp_i_rdata;
        logic        exp_d_rvalid;
        logic [31:0] exp_d_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [13:0] ia, input logic dr,
                                 input logic dw, input logic [13:0] da,
                                 input logic [31:0] dwd, input logic [2:0] dt);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dwd;
        d_type  = dt;
    endtask

    // Leaves the bench at posedge+1 with reset released
    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 32'd0, LW);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        mem[5] = 32'hDEADBEEF;
        mem[3] = 32'h000000F0;

        //          ir  ia     dr  dw  da      wdata          type  ig  dg  st  maddr  irv irdata          drv drdata
        vecs[0] = '{1'b1, 14'd5, 1'b0, 1'b0, 14'd0, 32'd0, LW,
                    1'b1, 1'b0, 1'b0, 14'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0};
        vecs[1] = '{1'b0, 14'd0, 1'b1, 1'b1, 14'd10, 32'h12345678, SW,
                    1'b0, 1'b1, 1'b1, 14'd10, 1'b0, 32'hDEADBEEF, 1'b1, 32'd0};
        vecs[2] = '{1'b0, 14'd0, 1'b1, 1'b0, 14'd10, 32'd0, LW,
                    1'b0, 1'b1, 1'b0, 14'd10, 1'b0, 32'hDEADBEEF, 1'b1, 32'h12345678};
        vecs[3] = '{1'b0, 14'd0, 1'b1, 1'b0, 14'd3, 32'd0, LB,
                    1'b0, 1'b1, 1'b0, 14'd3, 1'b0, 32'hDEADBEEF, 1'b1, 32'hFFFFFFF0};
        vecs[4] = '{1'b0, 14'd0, 1'b1, 1'b0, 14'd3, 32'd0, LBU,
                    1'b0, 1'b1, 1'b0, 14'd3, 1'b0, 32'hDEADBEEF, 1'b1, 32'h000000F0};
        vecs[5] = '{1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 32'd0, LW,
                    1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h000000F0};

        // Reset values while reset is held
        rst_n = 1'b0;
        applyStimulus(1'b1, 14'd5, 1'b1, 1'b1, 14'd7, 32'hFFFFFFFF, SW);
        #2;
        checkOutput("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
        checkOutput("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        checkOutput("rst_is_store", {31'd0, m_is_store}, 32'd0);
        checkOutput("rst_m_addr", {18'd0, m_addr}, 32'd0);
        checkOutput("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        checkOutput("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        checkOutput("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
        doReset();

        // Vector table: each entry occupies one cycle
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].i_req, vecs[v].i_addr, vecs[v].d_req, vecs[v].d_we,
                          vecs[v].d_addr, vecs[v].d_wdata, vecs[v].d_type);
            #1;
            checkOutput($sformatf("v%0d_i_gnt", v), {31'd0, i_gnt}, {31'd0, vecs[v].exp_i_gnt});
            checkOutput($sformatf("v%0d_d_gnt", v), {31'd0, d_gnt}, {31'd0, vecs[v].exp_d_gnt});
            checkOutput($sformatf("v%0d_is_store", v), {31'd0, m_is_store}, {31'd0, vecs[v].exp_is_store});
            checkOutput($sformatf("v%0d_m_addr", v), {18'd0, m_addr}, {18'd0, vecs[v].exp_m_addr});
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_i_rvalid", v), {31'd0, i_rvalid}, {31'd0, vecs[v].exp_i_rvalid});
            checkOutput($sformatf("v%0d_i_rdata", v), i_rdata, vecs[v].exp_i_rdata);
            checkOutput($sformatf("v%0d_d_rvalid", v), {31'd0, d_rvalid}, {31'd0, vecs[v].exp_d_rvalid});
            checkOutput($sformatf("v%0d_d_rdata", v), d_rdata, vecs[v].exp_d_rdata);
        end
        checkOutput("table_conflict", {16'd0, conflict_cnt}, 32'd0);

        // Starvation: both request for 9 cycles, fetch forced in cycle 4
        doReset();
        applyStimulus(1'b1, 14'd5, 1'b1, 1'b0, 14'd3, 32'd0, LW);
        for (int c = 0; c < 9; c++) begin
            #1;
            checkOutput($sformatf("starve_c%0d_i_gnt", c), {31'd0, i_gnt}, {31'd0, c == 4});
            checkOutput($sformatf("starve_c%0d_d_gnt", c), {31'd0, d_gnt}, {31'd0, c != 4});
            @(posedge clk);
            #1;
            checkOutput($sformatf("starve_c%0d_i_rvalid", c), {31'd0, i_rvalid}, {31'd0, c == 4});
            checkOutput($sformatf("starve_c%0d_d_rvalid", c), {31'd0, d_rvalid}, {31'd0, c != 4});
        end
        checkOutput("starve_i_rdata", i_rdata, 32'hDEADBEEF);
        checkOutput("starve_conflict", {16'd0, conflict_cnt}, 32'd9);

        // Reset asserted while a data load is being granted
        applyStimulus(1'b0, 14'd0, 1'b1, 1'b0, 14'd3, 32'd0, LW);
        #1;
        checkOutput("midrst_pre_d_gnt", {31'd0, d_gnt}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_d_gnt", {31'd0, d_gnt}, 32'd0);
        checkOutput("midrst_m_addr", {18'd0, m_addr}, 32'd0);
        checkOutput("midrst_conflict", {16'd0, conflict_cnt}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("midrst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        checkOutput("midrst_d_rdata", d_rdata, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("postrst_d_gnt", {31'd0, d_gnt}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("postrst_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        checkOutput("postrst_d_rdata", d_rdata, 32'h000000F0);
        checkOutput("postrst_conflict", {16'd0, conflict_cnt}, 32'd0);
        applyStimulus(1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 32'd0, LW);
        @(posedge clk);
        #1;
        checkOutput("postrst_idle_d_rvalid", {31'd0, d_rvalid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
